// File: rtl/comptest_regs_pkg.sv
// ----------------------------------------------------------------------------
// comptest_regs_pkg : register map constants and counter helper for spi_regfile
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package comptest_regs_pkg;

  localparam int          CNT_W      = 16;
  localparam int          REG_COUNT  = 16;
  localparam int          CFG_COUNT  = 8;
  localparam logic [15:0] ID_DEFAULT = 16'hC0DE;

  localparam logic [6:0] ADDR_ID      = 7'h00;
  localparam logic [6:0] ADDR_CTRL    = 7'h01;
  localparam logic [6:0] ADDR_PULSE   = 7'h02;
  localparam logic [6:0] ADDR_CFG0    = 7'h03;
  localparam logic [6:0] ADDR_SCRATCH = 7'h0B;
  localparam logic [6:0] ADDR_STATUS  = 7'h0C;
  localparam logic [6:0] ADDR_WRCNT   = 7'h0D;
  localparam logic [6:0] ADDR_ERRCNT  = 7'h0E;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rise_detect.sv
// ----------------------------------------------------------------------------
// rise_detect : 0->1 detector; a level already high when reset releases is ignored
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic in,
  output logic rise
);

  logic prev_q;
  logic armed_q;

  // armed_q stays low for the first cycle after reset so a held strobe is absorbed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= in;
      armed_q <= 1'b1;
    end
  end

  assign rise = armed_q & in & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/spi_regfile.sv
// ----------------------------------------------------------------------------
// spi_regfile : SPI-facing register file (ID, ctrl, pulse, cfg, scratch, counters)
// Optional error counter at 0x0E when REGFILE_ERRCNT_EN is defined.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_regfile
  import comptest_regs_pkg::*;
#(
  parameter logic [15:0] ID_VALUE = ID_DEFAULT
) (
  input  logic         sys_clk,
  input  logic         reset_n,
  input  logic         adr_latched,
  input  logic         data_latched,
  input  logic [7:0]   adr,
  input  logic [15:0]  data_wr,
  output logic [15:0]  data_rd,
  input  logic [15:0]  status,
  output logic [15:0]  ctrl,
  output logic [15:0]  pulse,
  output logic [127:0] cfg
);

  logic adr_rise;
  logic data_rise;

  rise_detect u_adr_rise (
    .clk     (sys_clk),
    .reset_n (reset_n),
    .in      (adr_latched),
    .rise    (adr_rise)
  );

  rise_detect u_data_rise (
    .clk     (sys_clk),
    .reset_n (reset_n),
    .in      (data_latched),
    .rise    (data_rise)
  );

  logic [7:0]       adr_q, adr_d;
  logic             rd_pend_q, rd_pend_d;
  logic [15:0]      data_rd_q, data_rd_d;
  logic [15:0]      ctrl_q, ctrl_d;
  logic [15:0]      pulse_q, pulse_d;
  logic [15:0]      cfg_q [CFG_COUNT];
  logic [15:0]      cfg_d [CFG_COUNT];
  logic [15:0]      scratch_q, scratch_d;
  logic [CNT_W-1:0] wrcnt_q, wrcnt_d;
`ifdef REGFILE_ERRCNT_EN
  logic [CNT_W-1:0] errcnt_q, errcnt_d;
  logic             err_inc, err_clr;
`endif

  logic [15:0] rd_word;
  logic [6:0]  rd_idx;
  logic [7:0]  wadr;
  logic [6:0]  widx;
  logic        wr_inc;
  logic        wr_clr;
  logic        cfg_hit;

  assign rd_idx = adr_q[6:0];

  always_comb begin
    rd_word = '0;
    if (rd_idx < 7'(REG_COUNT)) begin
      case (rd_idx)
        ADDR_ID:      rd_word = ID_VALUE;
        ADDR_CTRL:    rd_word = ctrl_q;
        ADDR_SCRATCH: rd_word = scratch_q;
        ADDR_STATUS:  rd_word = status;
        ADDR_WRCNT:   rd_word = wrcnt_q;
`ifdef REGFILE_ERRCNT_EN
        ADDR_ERRCNT:  rd_word = errcnt_q;
`endif
        default:      rd_word = '0;
      endcase
      for (int k = 0; k < CFG_COUNT; k++) begin
        if (rd_idx == ADDR_CFG0 + 7'(k)) rd_word = cfg_q[k];
      end
    end
  end

  // A data edge coinciding with an address edge decodes against the incoming address
  assign wadr = adr_rise ? adr : adr_q;
  assign widx = wadr[6:0];

  always_comb begin
    adr_d     = adr_rise ? adr : adr_q;
    rd_pend_d = adr_rise;
    data_rd_d = rd_pend_q ? rd_word : data_rd_q;
    ctrl_d    = ctrl_q;
    pulse_d   = '0;
    cfg_d     = cfg_q;
    scratch_d = scratch_q;
    wr_inc    = 1'b0;
    wr_clr    = 1'b0;
    cfg_hit   = 1'b0;
`ifdef REGFILE_ERRCNT_EN
    err_clr   = 1'b0;
`endif
    if (data_rise && wadr[7]) begin
      for (int k = 0; k < CFG_COUNT; k++) begin
        if (widx == ADDR_CFG0 + 7'(k)) begin
          cfg_d[k] = data_wr;
          cfg_hit  = 1'b1;
        end
      end
      case (widx)
        ADDR_CTRL: begin
          ctrl_d = data_wr;
          wr_inc = 1'b1;
        end
        ADDR_PULSE: begin
          pulse_d = data_wr;
          wr_inc  = 1'b1;
        end
        ADDR_SCRATCH: begin
          scratch_d = data_wr;
          wr_inc    = 1'b1;
        end
        ADDR_WRCNT: wr_clr = (data_wr == 16'h0000);
`ifdef REGFILE_ERRCNT_EN
        ADDR_ERRCNT: err_clr = (data_wr == 16'h0000);
`endif
        default: wr_inc = cfg_hit;
      endcase
    end
  end

`ifdef REGFILE_ERRCNT_EN
  // Any enabled write that neither stores nor clears is a write to RO/reserved space
  assign err_inc  = data_rise & wadr[7] & ~wr_inc & ~wr_clr & ~err_clr;
  assign errcnt_d = err_clr ? '0 : (err_inc ? sat_inc(errcnt_q) : errcnt_q);
`endif

  assign wrcnt_d = wr_clr ? '0 : (wr_inc ? sat_inc(wrcnt_q) : wrcnt_q);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      adr_q     <= '0;
      rd_pend_q <= 1'b0;
      data_rd_q <= '0;
      ctrl_q    <= '0;
      pulse_q   <= '0;
      scratch_q <= '0;
      wrcnt_q   <= '0;
      for (int k = 0; k < CFG_COUNT; k++) cfg_q[k] <= '0;
    end else begin
      adr_q     <= adr_d;
      rd_pend_q <= rd_pend_d;
      data_rd_q <= data_rd_d;
      ctrl_q    <= ctrl_d;
      pulse_q   <= pulse_d;
      scratch_q <= scratch_d;
      wrcnt_q   <= wrcnt_d;
      for (int k = 0; k < CFG_COUNT; k++) cfg_q[k] <= cfg_d[k];
    end
  end

`ifdef REGFILE_ERRCNT_EN
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) errcnt_q <= '0;
    else          errcnt_q <= errcnt_d;
  end
`endif

  assign data_rd = data_rd_q;
  assign ctrl    = ctrl_q;
  assign pulse   = pulse_q;

  for (genvar k = 0; k < CFG_COUNT; k++) begin : g_cfg
    assign cfg[16*k +: 16] = cfg_q[k];
  end

endmodule

`default_nettype wire
